// File: rtl/sobel_frame_ctrl.sv
// Purpose: frame sequencer between uart_rx and sobel_algorithm.
// Latency: a strobe sampled in cycle N drives pix_en/sof/eol/eof/col/row in cycle N+1.
// Backpressure: none; strobes are always taken except in the one-cycle DONE/ABORT states, where they are dropped.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   rx_valid_flag        one-cycle pulse per received byte
//   thr_req[7:0]         threshold requested by key logic
//   pix_en, sof, eol,    registered one-cycle pixel strobe and frame markers
//   eof, col, row        (col/row hold between strobes)
//   thr_active[7:0]      threshold of the current frame, latched only in IDLE
//   busy                 high while a frame is in progress
//   frame_abort          one-cycle pulse when a frame is dropped on a gap timeout
//   frame_cnt[7:0]       completed frames, wraps 255 -> 0
//
// Build option FRAME_CTRL_TIMEOUT_EN: when defined, an inter-byte gap watchdog
// aborts a stalled frame; when undefined, the watchdog is absent, frame_abort
// is tied low and a stalled frame waits in RECV until reset.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W       = 100,
  parameter int unsigned IMG_H       = 100,
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter logic [7:0]  THR_INIT    = 8'd100
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_valid_flag,
  input  logic [7:0] thr_req,
  output logic       pix_en,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic [7:0] thr_active,
  output logic       busy,
  output logic       frame_abort,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DONE, ABORT} state_t;

  state_t     state_q, state_d;

  // Position of the next pixel expected in the frame.
  logic [9:0] pos_col_q, pos_row_q, pos_col_d, pos_row_d;
  logic       last_col, last_row;

  logic       pix_en_d, sof_d, eol_d, eof_d, busy_d, abort_d;
  logic [9:0] col_d, row_d;
  logic [7:0] thr_d, cnt_d;

  // High when the gap counter is about to reach TIMEOUT_CYC-1 with no strobe.
  logic       gap_hit;

  assign last_col = (pos_col_q == 10'(IMG_W - 1));
  assign last_row = (pos_row_q == 10'(IMG_H - 1));

`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);

  logic [GAP_W-1:0] gap_q;

  // Counts RECV cycles without a strobe; a strobe always clears it, so a
  // strobe coinciding with the terminal count keeps the frame alive.
  assign gap_hit = (state_q == RECV) && !rx_valid_flag &&
                   (gap_q == GAP_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_q <= '0;
    end else if (state_q == RECV && !rx_valid_flag) begin
      gap_q <= gap_q + GAP_W'(1);
    end else begin
      gap_q <= '0;
    end
  end
`else
  assign gap_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_valid_flag) state_d = RECV;
      RECV: begin
        if (rx_valid_flag && last_col && last_row) begin
          state_d = DONE;
        end else if (gap_hit) begin
          state_d = ABORT;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and position counters
  always_comb begin
    pix_en_d  = 1'b0;
    sof_d     = 1'b0;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    abort_d   = 1'b0;
    col_d     = col;
    row_d     = row;
    thr_d     = thr_active;
    busy_d    = busy;
    cnt_d     = frame_cnt;
    pos_col_d = pos_col_q;
    pos_row_d = pos_row_q;
    case (state_q)
      IDLE: begin
        // Threshold follows the keys only while no frame is open.
        thr_d     = thr_req;
        pos_col_d = '0;
        pos_row_d = '0;
        if (rx_valid_flag) begin
          pix_en_d  = 1'b1;
          sof_d     = 1'b1;
          col_d     = '0;
          row_d     = '0;
          busy_d    = 1'b1;
          pos_col_d = 10'd1;
        end
      end
      RECV: begin
        if (rx_valid_flag) begin
          pix_en_d = 1'b1;
          col_d    = pos_col_q;
          row_d    = pos_row_q;
          if (last_col) begin
            eol_d     = 1'b1;
            eof_d     = last_row;
            pos_col_d = '0;
            pos_row_d = pos_row_q + 10'd1;
          end else begin
            pos_col_d = pos_col_q + 10'd1;
          end
        end else if (gap_hit) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        cnt_d  = frame_cnt + 8'd1;
      end
      ABORT: begin
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and position registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_en     <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      col        <= '0;
      row        <= '0;
      thr_active <= THR_INIT;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      pos_col_q  <= '0;
      pos_row_q  <= '0;
    end else begin
      pix_en     <= pix_en_d;
      sof        <= sof_d;
      eol        <= eol_d;
      eof        <= eof_d;
      col        <= col_d;
      row        <= row_d;
      thr_active <= thr_d;
      busy       <= busy_d;
      frame_cnt  <= cnt_d;
      pos_col_q  <= pos_col_d;
      pos_row_q  <= pos_row_d;
    end
  end

`ifdef FRAME_CTRL_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort_d;
    end
  end
`else
  assign frame_abort = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx_valid_flag = 1'b0;
  logic [7:0] thr_req = 8'd60;
  logic       pix_en, sof, eol, eof, busy, frame_abort;
  logic [9:0] col, row;
  logic [7:0] thr_active, frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  sobel_frame_ctrl #(
    .IMG_W(4), .IMG_H(3), .TIMEOUT_CYC(50), .THR_INIT(8'd100)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_valid_flag(rx_valid_flag),
    .thr_req(thr_req), .pix_en(pix_en), .sof(sof), .eol(eol), .eof(eof),
    .col(col), .row(row), .thr_active(thr_active), .busy(busy),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  // Expected markers for each pixel of a 4x3 frame, in arrival order.
  typedef struct {
    int   col;
    int   row;
    logic sof;
    logic eol;
    logic eof;
  } pix_vec_t;

  pix_vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One-cycle strobe; on return the outputs for that strobe are visible.
  task automatic strobe();
    rx_valid_flag = 1'b1;
    tick();
    rx_valid_flag = 1'b0;
  endtask

  // Full 12-pixel frame, one strobe every `spacing` cycles (spacing >= 2).
  task automatic frame_pixels(input string tag, input int spacing, input int thr_exp,
                              input int chg_at, input logic [7:0] chg_val);
    for (int i = 0; i < 12; i++) begin
      strobe();
      chk($sformatf("%s_pix_en%0d", tag, i), pix_en, 1);
      chk($sformatf("%s_sof%0d", tag, i), sof, vec[i].sof);
      chk($sformatf("%s_eol%0d", tag, i), eol, vec[i].eol);
      chk($sformatf("%s_eof%0d", tag, i), eof, vec[i].eof);
      chk($sformatf("%s_col%0d", tag, i), col, vec[i].col);
      chk($sformatf("%s_row%0d", tag, i), row, vec[i].row);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_thr%0d", tag, i), thr_active, thr_exp);
      if (i == chg_at) thr_req = chg_val;
      if (i < 11) begin
        tick();
        chk($sformatf("%s_pix_pulse%0d", tag, i), pix_en, 0);
        repeat (spacing - 2) tick();
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int first_abort, abort_cycles, busy_low, eof_seen, busy_at_abort;

    vec[0]  = '{0, 0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1, 0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{2, 0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{3, 0, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{0, 1, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1, 1, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{2, 1, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{3, 1, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{0, 2, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1, 2, 1'b0, 1'b0, 1'b0};
    vec[10] = '{2, 2, 1'b0, 1'b0, 1'b0};
    vec[11] = '{3, 2, 1'b0, 1'b1, 1'b1};

    // 1. Reset values, then threshold latched one cycle after release.
    #12;
    chk("rst_thr", thr_active, 100);
    chk("rst_pix_en", pix_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_eof", eof, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_rst_thr", thr_active, 60);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pix_en", pix_en, 0);

    // 2+3. Full frame, strobes 10 cycles apart; thr_req changes after strobe #3.
    frame_pixels("f1", 10, 60, 2, 8'd200);
    tick();
    chk("f1_done_busy", busy, 0);
    chk("f1_done_cnt", frame_cnt, 1);
    chk("f1_done_thr_frozen", thr_active, 60);
    tick();
    chk("f1_idle_thr", thr_active, 200);

`ifdef FRAME_CTRL_TIMEOUT_EN
    // 4. Five strobes, then a stall: abort 49 cycles after the 5th pixel strobe.
    for (int i = 0; i < 5; i++) begin
      strobe();
      if (i < 4) tick();
    end
    first_abort = -1; abort_cycles = 0; eof_seen = 0; busy_at_abort = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (frame_abort === 1'b1) begin
        abort_cycles++;
        if (first_abort < 0) begin
          first_abort = k;
          busy_at_abort = int'(busy);
        end
      end
      if (eof === 1'b1) eof_seen++;
    end
    chk("abort_delay", first_abort, 49);
    chk("abort_width", abort_cycles, 1);
    chk("abort_busy", busy_at_abort, 0);
    chk("abort_no_eof", eof_seen, 0);
    chk("abort_cnt_same", frame_cnt, 1);
    strobe();
    chk("post_abort_sof", sof, 1);
    chk("post_abort_col", col, 0);
    chk("post_abort_row", row, 0);
    chk("post_abort_busy", busy, 1);
    for (int i = 1; i < 12; i++) begin
      tick();
      strobe();
    end
    tick(); tick();
    chk("post_abort_frame_cnt", frame_cnt, 2);

    // 5a. Strobe lands exactly on the terminal gap count: pixel wins.
    strobe();
    repeat (48) tick();
    strobe();
    chk("term_pix_en", pix_en, 1);
    chk("term_abort", frame_abort, 0);
    chk("term_col", col, 1);
    chk("term_busy", busy, 1);
    abort_cycles = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (frame_abort === 1'b1) abort_cycles++;
    end
    chk("term_gap_cleared", abort_cycles, 0);
    for (int i = 2; i < 12; i++) begin
      strobe();
      tick();
    end
    tick();
    chk("term_frame_cnt", frame_cnt, 3);
`else
    // 5b. No watchdog: a 200-cycle stall keeps the frame open.
    strobe();
    busy_low = 0; abort_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (busy !== 1'b1) busy_low++;
      if (frame_abort !== 1'b0) abort_cycles++;
    end
    chk("stall_busy_low", busy_low, 0);
    chk("stall_abort", abort_cycles, 0);
    for (int i = 1; i < 12; i++) begin
      strobe();
      chk($sformatf("stall_col%0d", i), col, vec[i].col);
      tick();
    end
    tick();
    chk("stall_frame_cnt", frame_cnt, 2);
`endif

    // 6. Reset mid-line after pixel #6, then a clean frame.
    for (int i = 0; i < 6; i++) begin
      strobe();
      if (i < 5) tick();
    end
    chk("pre_rst_col", col, 1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_pix_en", pix_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_col", col, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_thr", thr_active, 100);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rel_eof", eof, 0);
    chk("rel_abort", frame_abort, 0);
    chk("rel_thr", thr_active, 200);
    frame_pixels("f6", 2, 200, -1, 8'd0);

    // Strobe during DONE is dropped and does not open a frame.
    rx_valid_flag = 1'b1;
    tick();
    rx_valid_flag = 1'b0;
    chk("done_drop_pix_en", pix_en, 0);
    chk("done_drop_cnt", frame_cnt, 1);
    tick();
    chk("done_drop_busy", busy, 0);
    chk("done_drop_pix_en2", pix_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
